// File: rtl/sram_port_ctrl.sv
// Load/store front end for the sram block: request checking, sram port drive,
// lane extraction/extension and a 2-entry in-order response buffer.
module sram_port_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_rdata,
  output logic                          resp_err,
  output logic                          sram_read_req,
  output logic [$clog2(DEPTH)-1:0]      sram_read_addr,
  input  logic [31:0]                   sram_read_data,
  output logic                          sram_write_req,
  output logic [$clog2(DEPTH)-1:0]      sram_write_addr,
  output logic [3:0]                    sram_write_byte_en,
  output logic [31:0]                   sram_write_data
);

  localparam int LOGDEPTH = $clog2(DEPTH);

  // Request decode
  logic                w_err;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic [LOGDEPTH-1:0] w_word_addr;
  logic [3:0]          w_byte_en;
  logic [31:0]         w_wdata_rep;

  // Pending (accepted last cycle) request
  logic                r_pend_valid;
  logic                r_pend_write;
  logic                r_pend_err;
  logic [1:0]          r_pend_size;
  logic                r_pend_unsigned;
  logic [1:0]          r_pend_lane;

  // Response buffer
  logic [31:0]         r_buf_data [2];
  logic                r_buf_err  [2];
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_count;

  logic [7:0]          w_lane_byte;
  logic [15:0]         w_lane_half;
  logic [31:0]         w_push_data;

  always_comb begin
    w_err = 1'b0;
    case (req_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = req_addr[0];
      2'b10:   w_err = (req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
    if ((req_addr >> (LOGDEPTH + 2)) != 32'd0) w_err = 1'b1;
  end

  assign w_pop     = resp_valid && resp_ready;
  assign w_occ     = {1'b0, r_count} + {2'b00, r_pend_valid} - {2'b00, w_pop};
  // resp_ready feeds req_ready combinationally so a full pipe still sustains one request per cycle.
  assign req_ready = reset_n && (w_occ < 3'd2);
  assign w_accept  = req_valid && req_ready;

  assign w_word_addr = req_addr[LOGDEPTH+1:2];

  always_comb begin
    w_byte_en   = 4'b1111;
    w_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        w_byte_en   = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_byte_en   = 4'b0011 << {req_addr[1], 1'b0};
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        w_byte_en   = 4'b1111;
        w_wdata_rep = req_wdata;
      end
    endcase
  end

  always_comb begin
    sram_read_req      = 1'b0;
    sram_read_addr     = '0;
    sram_write_req     = 1'b0;
    sram_write_addr    = '0;
    sram_write_byte_en = 4'b0000;
    sram_write_data    = 32'd0;
    if (w_accept && !w_err) begin
      if (req_write) begin
        sram_write_req     = 1'b1;
        sram_write_addr    = w_word_addr;
        sram_write_byte_en = w_byte_en;
        sram_write_data    = w_wdata_rep;
      end else begin
        sram_read_req  = 1'b1;
        sram_read_addr = w_word_addr;
      end
    end
  end

  assign w_lane_byte = sram_read_data[{r_pend_lane, 3'b000} +: 8];
  assign w_lane_half = sram_read_data[{r_pend_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_push_data = 32'd0;
    if (!r_pend_write && !r_pend_err) begin
      case (r_pend_size)
        2'b00:   w_push_data = r_pend_unsigned ? {24'd0, w_lane_byte}
                                               : {{24{w_lane_byte[7]}}, w_lane_byte};
        2'b01:   w_push_data = r_pend_unsigned ? {16'd0, w_lane_half}
                                               : {{16{w_lane_half[15]}}, w_lane_half};
        default: w_push_data = sram_read_data;
      endcase
    end
  end

  assign w_push = r_pend_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend_valid    <= 1'b0;
      r_pend_write    <= 1'b0;
      r_pend_err      <= 1'b0;
      r_pend_size     <= 2'b00;
      r_pend_unsigned <= 1'b0;
      r_pend_lane     <= 2'b00;
      r_buf_data[0]   <= 32'd0;
      r_buf_data[1]   <= 32'd0;
      r_buf_err[0]    <= 1'b0;
      r_buf_err[1]    <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_pend_valid <= w_accept;
      if (w_accept) begin
        r_pend_write    <= req_write;
        r_pend_err      <= w_err;
        r_pend_size     <= req_size;
        r_pend_unsigned <= req_unsigned;
        r_pend_lane     <= req_addr[1:0];
      end
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_push_data;
        r_buf_err[r_wr_ptr]  <= r_pend_err;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign resp_valid = (r_count != 2'd0);
  assign resp_rdata = r_buf_data[r_rd_ptr];
  assign resp_err   = r_buf_err[r_rd_ptr];

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural byte-enabled sram attached.
module tb_sram_port_ctrl;

  localparam int DEPTH    = 1024;
  localparam int LOGDEPTH = 10;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [31:0]         req_addr;
  logic [1:0]          req_size;
  logic                req_unsigned;
  logic [31:0]         req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_rdata;
  logic                resp_err;
  logic                sram_read_req;
  logic [LOGDEPTH-1:0] sram_read_addr;
  logic [31:0]         sram_read_data;
  logic                sram_write_req;
  logic [LOGDEPTH-1:0] sram_write_addr;
  logic [3:0]          sram_write_byte_en;
  logic [31:0]         sram_write_data;

  int n_checks = 0;
  int n_fail   = 0;
  int sram_pulses = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  always #5 clk = ~clk;

  sram_port_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .sram_read_req(sram_read_req), .sram_read_addr(sram_read_addr),
    .sram_read_data(sram_read_data),
    .sram_write_req(sram_write_req), .sram_write_addr(sram_write_addr),
    .sram_write_byte_en(sram_write_byte_en), .sram_write_data(sram_write_data)
  );

  // sram model: writes land at the edge, read data appears the cycle after the request
  always @(posedge clk) begin
    if (sram_write_req)
      for (int b = 0; b < 4; b++)
        if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
    if (sram_read_req) rd_q <= mem[sram_read_addr];
    if (sram_read_req || sram_write_req) sram_pulses <= sram_pulses + 1;
  end
  assign sram_read_data = rd_q;

  function automatic logic [31:0] wv(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_timeout addr=%h req_ready=%b required 1", a, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_resp(output logic [31:0] d, output logic e, output bit ok);
    int n;
    resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    ok = resp_valid;
    d  = resp_rdata;
    e  = resp_err;
    if (ok) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp valid=%b rdata=%h err=%b required 0/0/0", resp_valid, resp_rdata, resp_err);
    end
    n_checks++;
    if (req_ready !== 1'b0 || sram_read_req !== 1'b0 || sram_write_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req ready=%b rd=%b wr=%b required 0/0/0", req_ready, sram_read_req, sram_write_req);
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready got=%b required 1", req_ready);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] addrs [8] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h12, 32'h12, 32'h10, 32'h10};
    logic [1:0]  sizes [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        unsg  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [8] = '{32'h0000_00EF, 32'h0000_00BE, 32'h0000_00AD, 32'h0000_00DE,
                               32'hFFFF_FFAD, 32'hFFFF_DEAD, 32'h0000_BEEF, 32'hDEAD_BEEF};
    logic [31:0] d; logic e; bit ok;
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
    get_resp(d, e, ok);
    n_checks++;
    if (!ok || d !== 32'd0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL store_resp ok=%0d rdata=%h err=%b required 1/00000000/0", ok, d, e);
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, addrs[i], sizes[i], unsg[i], 32'h0);
      get_resp(d, e, ok);
      n_checks++;
      if (!ok || d !== exps[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL load_%0d addr=%h ok=%0d rdata=%h err=%b required %h/0", i, addrs[i], ok, d, e, exps[i]);
      end
    end
    // store then load of the same word on the very next cycle
    resp_ready = 1'b0;
    issue(1'b1, 32'h14, 2'b10, 1'b0, 32'h0BAD_F00D);
    issue(1'b0, 32'h14, 2'b10, 1'b0, 32'h0);
    get_resp(d, e, ok);
    get_resp(d, e, ok);
    n_checks++;
    if (!ok || d !== 32'h0BAD_F00D || e !== 1'b0) begin
      n_fail++;
      $display("FAIL store_load_fwd ok=%0d rdata=%h required 0badf00d", ok, d);
    end
  endtask

  task automatic test_half_store();
    logic [31:0] d; logic e; bit ok;
    issue(1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFE_5678);
    get_resp(d, e, ok);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h22; req_size = 2'b01;
    req_unsigned = 1'b0; req_wdata = 32'hAAAA_1234;
    #1;
    n_checks++;
    if (sram_write_req !== 1'b1 || sram_write_byte_en !== 4'b1100 ||
        sram_write_data !== 32'h1234_1234 || sram_write_addr !== 10'd8 || sram_read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL half_store_drive wr=%b be=%b data=%h addr=%0d required 1/1100/12341234/8",
               sram_write_req, sram_write_byte_en, sram_write_data, sram_write_addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    get_resp(d, e, ok);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h31; req_size = 2'b00;
    req_wdata = 32'hFFFF_FF5A;
    #1;
    n_checks++;
    if (sram_write_byte_en !== 4'b0010 || sram_write_data !== 32'h5A5A_5A5A || sram_write_addr !== 10'd12) begin
      n_fail++;
      $display("FAIL byte_store_drive be=%b data=%h addr=%0d required 0010/5a5a5a5a/12",
               sram_write_byte_en, sram_write_data, sram_write_addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    get_resp(d, e, ok);
    issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0);
    get_resp(d, e, ok);
    n_checks++;
    if (!ok || d !== 32'h1234_5678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL half_store_readback ok=%0d rdata=%h required 12345678", ok, d);
    end
  endtask

  task automatic test_errors();
    logic        wr    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] addrs [4] = '{32'h02, 32'h01, 32'h00, 32'h1000};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] d; logic e; bit ok;
    int p0;
    p0 = sram_pulses;
    for (int i = 0; i < 4; i++) begin
      issue(wr[i], addrs[i], sizes[i], 1'b0, 32'hFFFF_FFFF);
      get_resp(d, e, ok);
      n_checks++;
      if (!ok || e !== 1'b1 || d !== 32'd0) begin
        n_fail++;
        $display("FAIL err_%0d addr=%h ok=%0d err=%b rdata=%h required 1/00000000", i, addrs[i], ok, e, d);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (sram_pulses !== p0) begin
      n_fail++;
      $display("FAIL err_no_sram_pulse pulses=%0d required %0d", sram_pulses, p0);
    end
    // last word in range is legal
    issue(1'b1, 32'hFFC, 2'b10, 1'b0, 32'h7654_3210);
    get_resp(d, e, ok);
    issue(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0);
    get_resp(d, e, ok);
    n_checks++;
    if (!ok || e !== 1'b0 || d !== 32'h7654_3210) begin
      n_fail++;
      $display("FAIL top_word ok=%0d err=%b rdata=%h required 0/76543210", ok, e, d);
    end
  endtask

  task automatic test_stream();
    logic [31:0] d; logic e; bit ok;
    logic exp_v;
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 32'h100 + 32'(4 * i), 2'b10, 1'b0, wv(i));
      get_resp(d, e, ok);
    end
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      if (k < 8) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100 + 32'(4 * k);
        req_size = 2'b10; req_unsigned = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (k < 8) begin
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ready cycle=%0d got=%b required 1", k, req_ready);
        end
      end
      exp_v = (k >= 2 && k <= 9);
      n_checks++;
      if (resp_valid !== exp_v || (exp_v && resp_rdata !== wv(k - 2))) begin
        n_fail++;
        $display("FAIL stream_resp cycle=%0d valid=%b rdata=%h required %b/%h",
                 k, resp_valid, resp_rdata, exp_v, wv(k - 2));
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ready_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic rv_exp    [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   ri_exp    [8] = '{0, 0, 4, 4, 5, 6, 7, 0};
    int idx;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_checks++;
        if (idx !== 2 || req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_accepted count=%0d ready=%b required 2/0", idx, req_ready);
        end
      end
      resp_ready = (k >= 3);
      req_valid = (idx < 4); req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h100 + 32'(4 * (4 + idx));
      #1;
      n_checks++;
      if (req_ready !== ready_exp[k] || resp_valid !== rv_exp[k] ||
          (rv_exp[k] && resp_rdata !== wv(ri_exp[k]))) begin
        n_fail++;
        $display("FAIL bp_cycle_%0d ready=%b valid=%b rdata=%h required %b/%b/%h",
                 k, req_ready, resp_valid, resp_rdata, ready_exp[k], rv_exp[k], wv(ri_exp[k]));
      end
      if (req_valid && req_ready) idx++;
    end
    req_valid = 1'b0;
    n_checks++;
    if (idx !== 4) begin
      n_fail++;
      $display("FAIL bp_total_accepted got=%0d required 4", idx);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] d; logic e; bit ok;
    int stray;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_size = 2'b10; req_unsigned = 1'b0;
    @(negedge clk);
    req_addr = 32'h104;
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre ready=%b valid=%b required 0/1", req_ready, resp_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_resp valid=%b rdata=%h err=%b required 0/0/0", resp_valid, resp_rdata, resp_err);
    end
    reset_n = 1'b1;
    resp_ready = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (resp_valid) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL flush_stray cycles_valid=%0d required 0", stray);
    end
    issue(1'b0, 32'h108, 2'b10, 1'b0, 32'h0);
    get_resp(d, e, ok);
    n_checks++;
    if (!ok || d !== wv(2) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_reload ok=%0d rdata=%h required %h", ok, d, wv(2));
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (resp_valid) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL flush_dup cycles_valid=%0d required 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_byte_half();
    test_half_store();
    test_errors();
    test_stream();
    test_back_to_back();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
